// File: rtl/h_resp_ctrl_if.sv
// AHB data-phase / APB completion signals seen by the response controller,
// plus the error-mask, statistics-clear and debug statistics outputs.
interface h_resp_ctrl_if #(
    parameter int NUM_SLV = 4,
    parameter int CNT_W   = 16
) ();
    localparam int SLV_W = $clog2(NUM_SLV);

    logic [1:0]         h_trans;
    logic               h_sel;
    logic               h_ready_in;
    logic               slave_error;
    logic [NUM_SLV-1:0] p_sel;
    logic               p_enable;
    logic [NUM_SLV-1:0] p_ready;
    logic [NUM_SLV-1:0] p_slverr;
    logic [NUM_SLV-1:0] err_mask;
    logic               clr_stat;
    logic               h_resp;
    logic               h_readyout;
    logic               p_abort;
    logic [CNT_W-1:0]   err_cnt;
    logic [1:0]         err_code;
    logic [SLV_W-1:0]   err_slv;

    modport slave (
        input  h_trans, h_sel, h_ready_in, slave_error,
        input  p_sel, p_enable, p_ready, p_slverr, err_mask, clr_stat,
        output h_resp, h_readyout, p_abort, err_cnt, err_code, err_slv
    );

    modport master (
        output h_trans, h_sel, h_ready_in, slave_error,
        output p_sel, p_enable, p_ready, p_slverr, err_mask, clr_stat,
        input  h_resp, h_readyout, p_abort, err_cnt, err_code, err_slv
    );
endinterface

// File: rtl/h_resp_ctrl.sv
// AHB response/wait-state controller for the AHB-APB bridge: OKAY/ERROR
// responses, PREADY timeout with abort, and error statistics.
//
// state | meaning
// IDLE  | no data phase pending, zero-wait OKAY (readyout=1, resp=0)
// WAIT  | APB access in flight, wait states inserted (0,0)
// ERR1  | first ERROR cycle (0,1)
// ERR2  | second ERROR cycle, ends data phase, may accept next (1,1)
module h_resp_ctrl #(
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 16
) (
    input  logic          h_clk,
    input  logic          h_resetn,
    h_resp_ctrl_if.slave  bus
);
    localparam int SLV_W = $clog2(NUM_SLV);
    localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t             state, state_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic               accept, done, slv_err, timeout;
    logic [NUM_SLV-1:0] hit;
    logic [SLV_W-1:0]   sel_idx;
    logic               abort_nxt, err_upd, slv_upd;
    logic [1:0]         code_nxt;

    logic               resp_q, readyout_q, abort_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         code_q;
    logic [SLV_W-1:0]   slv_q;

    assign accept  = bus.h_sel & bus.h_ready_in & bus.h_trans[1];
    assign hit     = bus.p_sel & bus.p_ready;
    assign done    = bus.p_enable & (|hit);
    assign slv_err = |(hit & bus.p_slverr & ~bus.err_mask);
    assign timeout = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    // p_sel is one-hot; scanning downwards leaves the lowest set bit.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (bus.p_sel[i]) sel_idx = SLV_W'(i);
        end
    end

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        abort_nxt  = 1'b0;
        err_upd    = 1'b0;
        slv_upd    = 1'b0;
        code_nxt   = 2'b00;
        case (state)
            IDLE, ERR2: begin
                state_nxt = IDLE;
                if (accept) begin
                    if (bus.slave_error) begin
                        state_nxt = ERR1;
                        err_upd   = 1'b1;
                        code_nxt  = 2'b10;
                    end else begin
                        state_nxt  = WAIT;
                        to_cnt_nxt = '0;
                    end
                end
            end
            WAIT: begin
                if (done) begin
                    if (slv_err) begin
                        state_nxt = ERR1;
                        err_upd   = 1'b1;
                        slv_upd   = 1'b1;
                        code_nxt  = 2'b01;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (timeout) begin
                    state_nxt = ERR1;
                    abort_nxt = 1'b1;
                    err_upd   = 1'b1;
                    slv_upd   = 1'b1;
                    code_nxt  = 2'b11;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            ERR1:    state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            state      <= IDLE;
            to_cnt     <= '0;
            readyout_q <= 1'b1;
            resp_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            to_cnt     <= to_cnt_nxt;
            readyout_q <= (state_nxt == IDLE) || (state_nxt == ERR2);
            resp_q     <= (state_nxt == ERR1) || (state_nxt == ERR2);
            abort_q    <= abort_nxt;
        end
    end

    // Clear takes priority over an error captured in the same cycle.
    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            cnt_q  <= '0;
            code_q <= 2'b00;
            slv_q  <= '0;
        end else if (bus.clr_stat) begin
            cnt_q  <= '0;
            code_q <= 2'b00;
            slv_q  <= '0;
        end else if (err_upd) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
            code_q <= code_nxt;
            if (slv_upd) slv_q <= sel_idx;
        end
    end

    assign bus.h_resp     = resp_q;
    assign bus.h_readyout = readyout_q;
    assign bus.p_abort    = abort_q;
    assign bus.err_cnt    = cnt_q;
    assign bus.err_code   = code_q;
    assign bus.err_slv    = slv_q;
endmodule

// File: tb/tb_h_resp_ctrl.sv
// Directed bench for h_resp_ctrl with a short timeout and a 2-bit error
// counter so timeout and saturation are reachable in a few cycles.
module tb_h_resp_ctrl;
    localparam int NUM_SLV = 4;
    localparam int CNT_W   = 2;

    logic h_clk;
    logic h_resetn;
    int   n_tests;
    int   n_fail;

    h_resp_ctrl_if #(.NUM_SLV(NUM_SLV), .CNT_W(CNT_W)) bus ();

    h_resp_ctrl #(
        .NUM_SLV (NUM_SLV),
        .TIMEOUT (4),
        .TO_W    (3),
        .CNT_W   (CNT_W)
    ) dut (
        .h_clk    (h_clk),
        .h_resetn (h_resetn),
        .bus      (bus.slave)
    );

    initial h_clk = 1'b0;
    always #5 h_clk = ~h_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ro(input string tag, input logic rdy, input logic resp);
        chk({tag, ".readyout"}, 32'(bus.h_readyout), 32'(rdy));
        chk({tag, ".resp"}, 32'(bus.h_resp), 32'(resp));
    endtask

    task automatic chk_stat(input string tag, input int cnt, input int code, input int slv);
        chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(cnt));
        chk({tag, ".err_code"}, 32'(bus.err_code), 32'(code));
        chk({tag, ".err_slv"}, 32'(bus.err_slv), 32'(slv));
    endtask

    task automatic step();
        @(posedge h_clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.h_sel       = 1'b0;
        bus.h_trans     = 2'b00;
        bus.slave_error = 1'b0;
        bus.p_sel       = '0;
        bus.p_enable    = 1'b0;
        bus.p_ready     = '0;
        bus.p_slverr    = '0;
    endtask

    task automatic req(input logic dec_err);
        bus.h_sel       = 1'b1;
        bus.h_trans     = 2'b10;
        bus.h_ready_in  = 1'b1;
        bus.slave_error = dec_err;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        h_resetn = 1'b0;
        idle_bus();
        bus.h_ready_in = 1'b1;
        bus.err_mask   = '0;
        bus.clr_stat   = 1'b0;
        repeat (2) @(posedge h_clk);
        #1;
        chk_ro("reset", 1'b1, 1'b0);
        chk("reset.abort", 32'(bus.p_abort), 32'd0);
        chk_stat("reset", 0, 0, 0);
        @(negedge h_clk);
        h_resetn = 1'b1;

        // Completion from slave 2 on the third wait cycle
        req(1'b0);
        step(); chk_ro("ok.w1", 1'b0, 1'b0);
        idle_bus(); bus.p_sel = 4'b0100;
        step(); chk_ro("ok.w2", 1'b0, 1'b0);
        bus.p_enable = 1'b1;
        step(); chk_ro("ok.w3", 1'b0, 1'b0);
        bus.p_ready = 4'b0100;
        step(); chk_ro("ok.done", 1'b1, 1'b0);
        chk("ok.cnt", 32'(bus.err_cnt), 32'd0);
        idle_bus();

        // Decode error
        req(1'b1);
        step(); chk_ro("dec.e1", 1'b0, 1'b1);
        chk_stat("dec", 1, 2, 0);
        idle_bus();
        step(); chk_ro("dec.e2", 1'b1, 1'b1);
        step(); chk_ro("dec.idle", 1'b1, 1'b0);

        // Unmasked PSLVERR from slave 3
        req(1'b0);
        step();
        idle_bus();
        bus.p_sel = 4'b1000; bus.p_enable = 1'b1; bus.p_ready = 4'b1000; bus.p_slverr = 4'b1000;
        step(); chk_ro("slv.e1", 1'b0, 1'b1);
        chk_stat("slv", 2, 1, 3);
        idle_bus();
        step(); chk_ro("slv.e2", 1'b1, 1'b1);
        step(); chk_ro("slv.idle", 1'b1, 1'b0);

        // Same error masked -> OKAY, stats untouched
        bus.err_mask = 4'b1000;
        req(1'b0);
        step();
        idle_bus();
        bus.p_sel = 4'b1000; bus.p_enable = 1'b1; bus.p_ready = 4'b1000; bus.p_slverr = 4'b1000;
        step(); chk_ro("mask.done", 1'b1, 1'b0);
        chk_stat("mask", 2, 1, 3);
        idle_bus();
        bus.err_mask = '0;

        // Timeout on slave 1 after four wait cycles
        req(1'b0);
        step();
        idle_bus(); bus.p_sel = 4'b0010; bus.p_enable = 1'b1;
        step(); chk("to.w2.abort", 32'(bus.p_abort), 32'd0);
        step();
        step(); chk_ro("to.w4", 1'b0, 1'b0);
        chk("to.w4.abort", 32'(bus.p_abort), 32'd0);
        step(); chk_ro("to.e1", 1'b0, 1'b1);
        chk("to.e1.abort", 32'(bus.p_abort), 32'd1);
        chk_stat("to", 3, 3, 1);
        idle_bus();
        step(); chk_ro("to.e2", 1'b1, 1'b1);
        chk("to.e2.abort", 32'(bus.p_abort), 32'd0);
        step();

        // Completion on the timeout cycle wins
        req(1'b0);
        step();
        idle_bus(); bus.p_sel = 4'b0001; bus.p_enable = 1'b1;
        step(); step(); step();
        bus.p_ready = 4'b0001;
        step(); chk_ro("tie.done", 1'b1, 1'b0);
        chk("tie.abort", 32'(bus.p_abort), 32'd0);
        chk("tie.code", 32'(bus.err_code), 32'd3);
        idle_bus();

        // Saturation, then back-to-back accept in ERR2
        req(1'b1);
        step(); chk_stat("sat", 3, 2, 1);
        idle_bus();
        step(); chk_ro("b2b.e2", 1'b1, 1'b1);
        req(1'b0);
        step(); chk_ro("b2b.wait", 1'b0, 1'b0);
        idle_bus(); bus.p_sel = 4'b0001; bus.p_enable = 1'b1; bus.p_ready = 4'b0001;
        step(); chk_ro("b2b.done", 1'b1, 1'b0);
        idle_bus();

        // Clear in the same cycle as a new error
        req(1'b1); bus.clr_stat = 1'b1;
        step(); chk_ro("clr.e1", 1'b0, 1'b1);
        chk_stat("clr", 0, 0, 0);
        idle_bus(); bus.clr_stat = 1'b0;
        step(); step();

        // Busy and idle transfers are zero-wait OKAY
        bus.h_sel = 1'b1; bus.h_trans = 2'b01;
        step(); chk_ro("busy", 1'b1, 1'b0);
        bus.h_trans = 2'b00;
        step(); chk_ro("idle", 1'b1, 1'b0);
        idle_bus();

        // Asynchronous reset in the middle of a wait
        req(1'b0);
        step(); chk_ro("rst.wait", 1'b0, 1'b0);
        idle_bus(); bus.p_sel = 4'b0010; bus.p_enable = 1'b1;
        #2 h_resetn = 1'b0;
        #1 chk_ro("rst.async", 1'b1, 1'b0);
        @(negedge h_clk);
        h_resetn = 1'b1;
        idle_bus();
        step(); chk_ro("rst.idle", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/h_resp_ctrl.md
Name: h_resp_ctrl

Overview:
- Parametrised AHB response/wait-state controller for the AHB-APB bridge; drives h_resp and h_readyout for every data phase.
- Generalises the single-slave error flag to NUM_SLV APB slaves with per-slave error masking.
- Generates the AHB two-cycle ERROR response, a PREADY timeout with abort, and error statistics for debug.

Parameters:
- NUM_SLV, 4, number of APB slaves (p_sel/p_ready/p_slverr width); must be >= 2.
- TIMEOUT, 255, max access-phase cycles before abort; 0 disables the timeout.
- TO_W, 8, timeout counter width; must hold TIMEOUT.
- CNT_W, 16, error counter width.

Ports:
- h_clk  input  1  AHB clock.
- h_resetn  input  1  asynchronous active-low reset.
- h_trans  input  2  AHB HTRANS (00 idle, 01 busy, 10 nonseq, 11 seq).
- h_sel  input  1  bridge selected.
- h_ready_in  input  1  bus HREADY; qualifies address phase.
- slave_error  input  1  address decode miss, valid with address phase.
- p_sel  input  NUM_SLV  APB PSELx, one-hot.
- p_enable  input  1  APB PENABLE.
- p_ready  input  NUM_SLV  per-slave PREADY.
- p_slverr  input  NUM_SLV  per-slave PSLVERR.
- err_mask  input  NUM_SLV  1 = suppress that slave's PSLVERR.
- clr_stat  input  1  synchronous clear of the statistics outputs.
- h_resp  output  1  AHB HRESP (0 OKAY, 1 ERROR).
- h_readyout  output  1  AHB HREADYOUT.
- p_abort  output  1  one-cycle pulse; bridge FSM drops the APB access.
- err_cnt  output  CNT_W  saturating error count.
- err_code  output  2  last error: 00 none, 01 slverr, 10 decode, 11 timeout.
- err_slv  output  $clog2(NUM_SLV)  index of the slave for the last slverr/timeout.

Behaviour:
- Interface: one clock, h_clk; h_resetn is asynchronous, active-low.
- Reset (async, also mid-transfer): state IDLE, h_readyout=1, h_resp=0, p_abort=0, err_cnt=0, err_code=00, err_slv=0, timeout counter=0.
- All outputs are registered.
- Accept condition: h_sel & h_ready_in & h_trans[1]. Idle and busy transfers never leave IDLE and get a zero-wait OKAY.
- FSM states, with outputs (h_readyout, h_resp):
  - IDLE (1,0): on accept with slave_error=1 -> ERR1, err_code=10. On accept with slave_error=0 -> WAIT, timeout counter cleared.
  - WAIT (0,0):
    - Completion = p_enable & |(p_sel & p_ready).
    - Completion with |(p_sel & p_ready & p_slverr & ~err_mask) -> ERR1, err_code=01, err_slv=index of lowest set p_sel bit.
    - Completion without an unmasked error -> IDLE; h_readyout goes high the next cycle.
    - Otherwise the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without completion -> ERR1, p_abort=1 for exactly one cycle, err_code=11, err_slv=index of lowest set p_sel bit.
    - Completion and timeout in the same cycle: completion wins.
  - ERR1 (0,1): unconditionally -> ERR2.
  - ERR2 (1,1): ends the data phase; uses the same accept logic as IDLE (a new transfer is taken here), else -> IDLE.
- Masked PSLVERR: treated as OKAY; not counted; err_code is not updated.
- Statistics:
  - err_cnt increments on every entry to ERR1 and saturates at all-ones.
  - err_code and err_slv update only on ERR1 entry and hold otherwise.
  - clr_stat zeroes all three and wins over a same-cycle update.
- Latency: decode error to first ERROR cycle = 1 clock after accept. APB completion to h_readyout=1 = 1 clock.

Test Plan:
- Reset, then a nonseq accept with slave_error=0; slave 2 raises p_ready with p_enable on the 3rd WAIT cycle and p_slverr=0 -> h_readyout low 3 cycles, high the next; h_resp=0; err_cnt=0.
- Nonseq accept with slave_error=1 -> next cycle (0,1), then (1,1), then IDLE; err_code=10; err_cnt=1.
- Slave 3 completes with p_slverr=1: with err_mask=0 -> two-cycle ERROR, err_code=01, err_slv=3. Repeat with err_mask[3]=1 -> OKAY; err_cnt unchanged.
- TIMEOUT=4 and p_ready held 0 -> abort on the 4th WAIT cycle, p_abort high exactly one cycle, then ERROR response, err_code=11. A completion on that same cycle -> OKAY, no abort.
- Errors with CNT_W=2 -> err_cnt saturates at 3. clr_stat asserted in the same cycle as a new error -> all stats 0. Reset asserted mid-WAIT -> immediately IDLE with h_readyout=1.
- Back-to-back: nonseq presented during ERR2 -> accepted, FSM goes to WAIT. Busy and idle transfers in IDLE -> h_readyout stays 1, h_resp stays 0.
